// File: rtl/adc_serial_responder_pkg.sv
// ---------------------------------------------------------------------------
// adc_serial_responder_pkg
// Shared definitions for the ambient-light ADC responder:
//   - state_t       : responder frame state machine encoding
//   - SYNC_STAGES   : depth of the input synchronizers for cs / sclk
//   - DEF_*         : default frame geometry (8-bit sample, 3 leading zeros,
//                     16-bit frame, 8-bit completed-frame counter)
// ---------------------------------------------------------------------------
package adc_serial_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SYNC_STAGES    = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEAD_BITS  = 3;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/adc_serial_responder_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Multi-stage synchronizer for an asynchronous pin followed by a registered
// edge detector producing one-cycle rise/fall pulses.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   din   in  asynchronous input pin
//   rise  out one-cycle pulse, synchronized din went 0 -> 1
//   fall  out one-cycle pulse, synchronized din went 1 -> 0
// Parameters:
//   STAGES    synchronizer depth (>= 2)
//   RESET_VAL value the whole chain holds during reset (idle pin level)
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;
    logic [STAGES:0]   primed_reg;
    logic              rise_reg;
    logic              fall_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[gi] <= RESET_VAL;
                    else      sync_reg[gi] <= din;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[gi] <= RESET_VAL;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // primed_reg fills with ones after reset release. Edges are suppressed
    // until the chain holds only real pin samples, so a pin that sits away
    // from RESET_VAL across reset release does not fake an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_reg   <= RESET_VAL;
            primed_reg <= '0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            prev_reg   <= sync_reg[STAGES-1];
            primed_reg <= {primed_reg[STAGES-1:0], 1'b1};
            rise_reg   <= primed_reg[STAGES] &  sync_reg[STAGES-1] & ~prev_reg;
            fall_reg   <= primed_reg[STAGES] & ~sync_reg[STAGES-1] &  prev_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/adc_serial_responder.sv
// ---------------------------------------------------------------------------
// adc_serial_responder
// Emulates the 8-bit ambient-light ADC on a cs/sclk/sdata serial link.
// On a cs fall it shifts out {LEAD_BITS zeros, sample, trailing zeros},
// MSB first, advancing one bit per sclk fall; the master samples on sclk rise.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   cs           in   active-low chip select (async to clk)
//   sclk         in   serial clock (async to clk), idles low
//   sdata        out  serial data, MSB first
//   sample       in   sample value for subsequent frames
//   sample_we    in   write strobe for the holding register
//   busy         out  frame in progress (SHIFT or DONE)
//   frame_done   out  one-cycle pulse after FRAME_BITS sclk rises
//   frame_abort  out  one-cycle pulse when cs rises mid-frame
//   frame_count  out  completed-frame counter, wraps
// ---------------------------------------------------------------------------
module adc_serial_responder
    import adc_serial_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEAD_BITS  = DEF_LEAD_BITS,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sclk,
    output logic                  sdata,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  sample_we,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    // FRAME_BITS - LEAD_BITS - DATA_WIDTH must not be negative.
    localparam int TRAIL_BITS = FRAME_BITS - LEAD_BITS - DATA_WIDTH;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [BIT_CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [CNT_WIDTH-1:0]    frame_count_reg, frame_count_next;
    logic                    frame_done_reg, frame_done_next;
    logic                    frame_abort_reg, frame_abort_next;
    logic [FRAME_BITS-1:0]   frame_load;

    // Sample zero-extended to the frame width then moved up past the
    // trailing zeros; the leading zeros fall out of the zero-extension.
    assign frame_load = FRAME_BITS'(hold_reg) << TRAIL_BITS;

    // The shift register loads from the registered hold value, so a write in
    // the same cycle as the cs-fall load only affects the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg <= '0;
        end else if (sample_we) begin
            hold_reg <= sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            frame_count_reg <= '0;
            frame_done_reg  <= 1'b0;
            frame_abort_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            frame_count_reg <= frame_count_next;
            frame_done_reg  <= frame_done_next;
            frame_abort_reg <= frame_abort_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        frame_count_next = frame_count_reg;
        frame_done_next  = 1'b0;
        frame_abort_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    shift_next   = frame_load;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    frame_abort_next = 1'b1;
                    state_next       = IDLE;
                end else if (sclk_rise) begin
                    // A rise wins over a simultaneous fall (sync glitch).
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_next == BIT_CNT_W'(FRAME_BITS)) begin
                        frame_done_next  = 1'b1;
                        frame_count_next = frame_count_reg + 1'b1;
                        state_next       = DONE;
                    end
                end else if (sclk_fall) begin
                    shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sdata       = (state_reg == SHIFT) && shift_reg[FRAME_BITS-1];
    assign busy        = (state_reg != IDLE);
    assign frame_done  = frame_done_reg;
    assign frame_abort = frame_abort_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: doc/adc_serial_responder.md
# adc_serial_responder

Serial-peripheral responder that emulates the 8-bit ambient-light ADC on the chip-select/serial-clock/serial-data link. It watches an externally driven active-low `cs` and `sclk` and shifts a 16-bit frame (leading zeros, sample, trailing zeros) out on `sdata`. It sits on the sensor side of the link, either as a loopback model for the on-board ADC reader or as the sensor stand-in when the real part is absent. Local logic loads the sample value through a write strobe.

## Interface
- `DATA_WIDTH`, 8: sample width.
- `LEAD_BITS`, 3: zero bits before the sample MSB.
- `FRAME_BITS`, 16: total bits per frame. Trailing zeros = FRAME_BITS − LEAD_BITS − DATA_WIDTH, which must be ≥ 0.
- `CNT_WIDTH`, 8: width of `frame_count`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select from master, active-low, asynchronous to `clk`.
- `sclk`  in  1  serial clock from master, asynchronous to `clk`.
- `sdata`  out  1  serial data to master, MSB first.
- `sample`  in  DATA_WIDTH  value for subsequent frames.
- `sample_we`  in  1  write strobe; captures `sample` into the holding register.
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when a full frame has been clocked.
- `frame_abort`  out  1  one-cycle pulse when `cs` rises before the frame completes.
- `frame_count`  out  CNT_WIDTH  count of completed frames; wraps to 0 after all-ones.

## Operation
- `cs` and `sclk` each pass through a 2-flop synchronizer, then a registered edge detector.
- Holding register `hold`:
  - Written on any cycle with `sample_we`=1, regardless of state.
  - Copied into the shift register only when a `cs` fall is detected.
- State machine: IDLE → SHIFT → DONE → IDLE.
- IDLE: `sdata`=0, `busy`=0. On a detected `cs` fall:
  - Load shift register with {LEAD_BITS zeros, `hold`, trailing zeros}.
  - Clear bit counter; go to SHIFT.
- SHIFT: `busy`=1; `sdata` = shift-register MSB.
  - Detected `sclk` fall: shift left one, zero-fill.
  - Detected `sclk` rise: bit counter +1.
  - When the counter reaches FRAME_BITS: pulse `frame_done`, increment `frame_count`, go to DONE.
  - Detected `cs` rise in SHIFT: pulse `frame_abort`, go to IDLE, leave `frame_count` unchanged.
- DONE: `busy`=1; `sdata`=0 for any further `sclk` edges. Detected `cs` rise → IDLE with no pulse.
- Simultaneous `sample_we` and detected `cs` fall: the current frame uses the old `hold`; the new value applies from the next frame.
- `sclk` fall and rise are never detected in the same cycle; if sync glitches make that happen, the rise is processed and the fall is ignored.
- Reset (async, `rst`=0):
  - `sdata`=0, `busy`=0, `frame_done`=0, `frame_abort`=0, `frame_count`=0, `hold`=0, state IDLE.
  - Synchronizer flops reset to `cs`=1, `sclk`=0.
  - If `cs` is still low at reset release, no frame starts until `cs` goes high and then falls again.

## Timing
- Edge-detect latency is 3 `clk` cycles from the pin transition to the detect cycle; outputs update on the following edge.
- Frame MSB appears on `sdata` 4 cycles after `cs` falls. Each subsequent bit appears 4 cycles after the `sclk` falling edge.
- Master requirements:
  - `sclk` high and low phases ≥ 8 `clk` cycles each.
  - First `sclk` fall ≥ 8 cycles after `cs` falls.
  - Master samples `sdata` on the `sclk` rising edge.
- `frame_done` asserts 4 cycles after the FRAME_BITS-th `sclk` rise.
- `frame_abort` asserts 4 cycles after `cs` rises.

## Structure
- Shared package holds:
  - state enum (IDLE, SHIFT, DONE)
  - `SYNC_STAGES`=2
  - default frame constants (LEAD_BITS, FRAME_BITS)
- One sub-module, `sync_edge_detect`: parameterized-stage synchronizer plus rise/fall pulse outputs and reset value. Instantiated twice, once for `cs` and once for `sclk`.

## Test plan
- Hold `rst`=0 with `cs`/`sclk` toggling → `sdata`=0, `busy`=0, `frame_count`=0, no pulses.
- Write 0xA5, then run one 16-bit frame with half-period 8 cycles → master captures 0x14A0; `frame_done` pulses exactly once; `frame_count`=1; no `frame_abort`.
- Write 0x3C mid-frame while sending 0xA5 → current frame 0x14A0; next frame 0x0780.
- `sample_we`=0x3C in the same cycle the `cs` fall is detected (`hold`=0xA5) → that frame 0x14A0; following frame 0x0780.
- Raise `cs` after 7 `sclk` rises → `frame_abort` pulses once; `frame_count` unchanged; next full frame correct.
- Send 20 `sclk` cycles in one frame → bits 17–20 read 0; one `frame_done`.
- Pull `rst` low mid-frame with `cs` held low, then release → state IDLE, `sdata`=0, no pulses until `cs` goes high and falls again.
